// File: rtl/rv32i_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// rv32i_hazard_scoreboard
//
// Tracks the destination registers of the instructions in the stages after
// decode (entry 0 = E ... entry DEPTH-1 = W). Decides load-use stalls, branch
// flushes, and the registered per-operand forwarding selects for the
// instruction that enters E.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   ena             global enable; 0 freezes every register
//   dec_valid       decode stage holds a real instruction
//   dec_rd          destination register of the decode instruction
//   dec_reg_write   decode instruction writes dec_rd
//   dec_is_load     decode instruction is a load
//   dec_rs          N_SRC source registers, port i at [5i+4:5i]
//   redirect_e      taken branch/jump resolved in E this cycle
//   stall_f/_d      hold PC + F/D register / hold decode stage
//   flush_d         clear F/D register on the next edge
//   flush_e         insert a bubble into D/E on the next edge
//   fwd_sel_e       per-port select for the E instruction: 0 = regfile,
//                   j = result of stage j (1 = M, 2 = W, ...)
//   stall_count     saturating count of stall cycles
// -----------------------------------------------------------------------------
module rv32i_hazard_scoreboard #(
    parameter int  DEPTH    = 3,
    parameter int  N_SRC    = 2,
    parameter int  LOAD_LAT = 1,
    parameter int  CNT_W    = 16,
    localparam int SELW     = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  dec_valid,
    input  logic [4:0]            dec_rd,
    input  logic                  dec_reg_write,
    input  logic                  dec_is_load,
    input  logic [N_SRC*5-1:0]    dec_rs,
    input  logic                  redirect_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [N_SRC*SELW-1:0] fwd_sel_e,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } entry_t;

    entry_t                      entry_q [DEPTH];
    entry_t                      entry0_d;
    logic [N_SRC*SELW-1:0]       fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic [N_SRC-1:0]            hit;
    logic [N_SRC-1:0]            hit_early_load;
    logic [N_SRC-1:0][SELW-1:0]  hit_k;
    logic                        load_hazard;
    logic                        issue;

    // Operand match. Entry DEPTH-1 (W) is excluded: the register file is
    // write-through, so the value is already visible to decode.
    // NOTE: every signal assigned in an always_comb gets a default at the top,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        hit            = '0;
        hit_early_load = '0;
        hit_k          = '0;
        for (int i = 0; i < N_SRC; i++) begin
            // Scan oldest to youngest so the youngest match overwrites older ones.
            for (int k = DEPTH - 2; k >= 0; k--) begin
                if (entry_q[k].valid && entry_q[k].reg_write &&
                    entry_q[k].rd == dec_rs[5*i +: 5] && dec_rs[5*i +: 5] != 5'd0) begin
                    hit[i]            = 1'b1;
                    hit_k[i]          = SELW'(k);
                    hit_early_load[i] = entry_q[k].is_load && (k < LOAD_LAT);
                end
            end
        end
    end

    // A load hazard only counts if the youngest producer is a load whose data
    // is not ready yet; an older load shadowed by a younger ALU op is harmless.
    assign load_hazard = dec_valid && |(hit & hit_early_load);

    // Inputs are don't-care during reset, so redirect_e is gated explicitly.
    assign stall_f     = load_hazard && !redirect_e && !rst;
    assign stall_d     = stall_f;
    assign flush_d     = redirect_e && !rst;
    assign flush_e     = (redirect_e || load_hazard) && !rst;
    assign fwd_sel_e   = fwd_sel_q;
    assign stall_count = count_q;

    assign issue = dec_valid && !stall_d && !redirect_e;

    always_comb begin
        entry0_d  = '0;
        fwd_sel_d = '0;
        if (issue) begin
            entry0_d.valid     = 1'b1;
            entry0_d.rd        = dec_rd;
            entry0_d.reg_write = dec_reg_write;
            entry0_d.is_load   = dec_is_load;
            // The producer at entry k moves to k+1 on this edge, which is
            // exactly the stage index the E-stage mux selects from.
            for (int i = 0; i < N_SRC; i++) begin
                if (hit[i]) begin
                    fwd_sel_d[i*SELW +: SELW] = hit_k[i] + SELW'(1);
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (stall_d && count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every entry
    // shifts from its pre-edge neighbour rather than a value updated earlier
    // in the same block.
    // NOTE: the tracking array is a handful of flops, not a RAM, so it is
    // reset in full; a valid bit left over from before reset would cause a
    // phantom stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= '0;
            end
            fwd_sel_q <= '0;
            count_q   <= '0;
        end else if (ena) begin
            entry_q[0] <= entry0_d;
            for (int k = 1; k < DEPTH; k++) begin
                entry_q[k] <= entry_q[k-1];
            end
            fwd_sel_q <= fwd_sel_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rv32i_hazard_scoreboard
//
// Drives directed instruction sequences into two scoreboards (default
// parameters, and CNT_W=2 for saturation). A behavioural model tracks the
// in-flight instructions as a list and derives stalls, flushes, forwarding
// selects and the stall count; outputs are compared against it on every
// falling edge, and a set of hand-computed literal checks pins the model.
// -----------------------------------------------------------------------------
module tb_rv32i_hazard_scoreboard;

    localparam int DEPTH    = 3;
    localparam int N_SRC    = 2;
    localparam int LOAD_LAT = 1;
    localparam int CNT_W    = 16;
    localparam int SAT_W    = 2;
    localparam int SELW     = 2;
    localparam int FW       = N_SRC * SELW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ena = 1'b1;
    logic               dec_valid = 1'b0;
    logic [4:0]         dec_rd = 5'd0;
    logic               dec_reg_write = 1'b0;
    logic               dec_is_load = 1'b0;
    logic [N_SRC*5-1:0] dec_rs = '0;
    logic               redirect_e = 1'b1;

    logic               stall_f, stall_d, flush_d, flush_e;
    logic [FW-1:0]      fwd_sel_e;
    logic [CNT_W-1:0]   stall_count;
    logic               s_stall_f, s_stall_d, s_flush_d, s_flush_e;
    logic [FW-1:0]      s_fwd_sel_e;
    logic [SAT_W-1:0]   s_stall_count;

    bit cmp_en = 1'b0;
    int n_vec  = 0;
    int n_err  = 0;

    rv32i_hazard_scoreboard #(
        .DEPTH(DEPTH), .N_SRC(N_SRC), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .ena(ena),
        .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
        .dec_is_load(dec_is_load), .dec_rs(dec_rs), .redirect_e(redirect_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_sel_e(fwd_sel_e), .stall_count(stall_count)
    );

    rv32i_hazard_scoreboard #(
        .DEPTH(DEPTH), .N_SRC(N_SRC), .LOAD_LAT(LOAD_LAT), .CNT_W(SAT_W)
    ) u_sat (
        .clk(clk), .rst(rst), .ena(ena),
        .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
        .dec_is_load(dec_is_load), .dec_rs(dec_rs), .redirect_e(redirect_e),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_d(s_flush_d), .flush_e(s_flush_e),
        .fwd_sel_e(s_fwd_sel_e), .stall_count(s_stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } instr_t;

    instr_t        pipe [DEPTH];   // pipe[0] = E, pipe[DEPTH-1] = W
    logic [FW-1:0] m_fwd;
    int unsigned   m_stalls;

    // Stage index of the youngest in-flight writer of rs that decode cannot
    // already read from the register file; -1 when there is none.
    function automatic int youngest_writer(input bit [4:0] rs);
        if (rs == 5'd0) return -1;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (pipe[k].valid && pipe[k].wr && pipe[k].rd == rs) return k;
        end
        return -1;
    endfunction

    function automatic bit model_hazard();
        int a;
        if (!dec_valid) return 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            a = youngest_writer(dec_rs[5*i +: 5]);
            if (a >= 0 && pipe[a].ld && a < LOAD_LAT) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) pipe[k] <= '{default: 0};
            m_fwd    <= '0;
            m_stalls <= 0;
        end else if (ena) begin : upd
            bit            stl;
            bit            iss;
            int            a;
            logic [FW-1:0] f;
            instr_t        nw;
            stl = model_hazard() && !redirect_e;
            iss = dec_valid && !stl && !redirect_e;
            f   = '0;
            for (int i = 0; i < N_SRC; i++) begin
                a = youngest_writer(dec_rs[5*i +: 5]);
                if (iss && a >= 0) f[i*SELW +: SELW] = SELW'(a + 1);
            end
            nw = '{default: 0};
            if (iss) begin
                nw.valid = 1'b1;
                nw.rd    = dec_rd;
                nw.wr    = dec_reg_write;
                nw.ld    = dec_is_load;
            end
            m_fwd <= f;
            if (stl) m_stalls <= m_stalls + 1;
            for (int k = DEPTH - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= nw;
        end
    end

    // Compare every falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin : cmp
            bit hz;
            bit stl;
            hz  = !rst && model_hazard();
            stl = hz && !redirect_e;
            check("stall_f", stall_f, stl);
            check("stall_d", stall_d, stl);
            check("flush_d", flush_d, !rst && redirect_e);
            check("flush_e", flush_e, !rst && (redirect_e || hz));
            check("fwd_sel_e", fwd_sel_e, m_fwd);
            check("stall_count", stall_count, (m_stalls > 65535) ? 65535 : m_stalls);
            check("sat_stall_d", s_stall_d, stl);
            check("sat_stall_count", s_stall_count, (m_stalls > 3) ? 3 : m_stalls);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input bit [4:0] rd, input bit wr, input bit ld,
                       input bit [4:0] rs0, input bit [4:0] rs1, input bit redir);
        dec_valid     = v;
        dec_rd        = rd;
        dec_reg_write = wr;
        dec_is_load   = ld;
        dec_rs        = {rs1, rs0};
        redirect_e    = redir;
    endtask

    task automatic drain();
        put(0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH) tick();
    endtask

    initial begin
        // Reset state, with redirect_e high to show it is ignored under reset.
        #2;
        check("rst_stall_f", stall_f, 0);
        check("rst_flush_d", flush_d, 0);
        check("rst_flush_e", flush_e, 0);
        check("rst_fwd", fwd_sel_e, 0);
        check("rst_count", stall_count, 0);
        #4 cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Back-to-back ALU: add x5 ; add x6,x5,x1
        put(1, 5, 1, 0, 1, 2, 0);
        #1 check("alu_p_stall", stall_d, 0);
        tick();
        put(1, 6, 1, 0, 5, 1, 0);
        #1 check("alu_c_stall", stall_d, 0);
        check("alu_c_flush_e", flush_e, 0);
        tick();
        check("alu_fwd", fwd_sel_e, 4'b0001);

        // Load-use: lw x5 ; add x7,x5,x5
        drain();
        put(1, 5, 1, 1, 2, 0, 0);
        tick();
        put(1, 7, 1, 0, 5, 5, 0);
        #1 check("lu_stall_f", stall_f, 1);
        check("lu_stall_d", stall_d, 1);
        check("lu_flush_e", flush_e, 1);
        check("lu_flush_d", flush_d, 0);
        tick();
        check("lu_count", stall_count, 1);
        check("lu_stall_gone", stall_d, 0);
        check("lu_bubble_fwd", fwd_sel_e, 0);
        tick();
        check("lu_fwd", fwd_sel_e, 4'b1010);

        // Redirect while a load hazard is present.
        drain();
        put(1, 8, 1, 1, 1, 0, 0);
        tick();
        put(1, 9, 1, 0, 8, 0, 1);
        #1 check("rd_flush_d", flush_d, 1);
        check("rd_flush_e", flush_e, 1);
        check("rd_stall_f", stall_f, 0);
        check("rd_stall_d", stall_d, 0);
        tick();
        check("rd_count", stall_count, 1);
        check("rd_fwd", fwd_sel_e, 0);

        // x0 producer never matches.
        drain();
        put(1, 0, 1, 1, 1, 2, 0);
        tick();
        put(1, 10, 1, 0, 0, 0, 0);
        #1 check("x0_stall", stall_d, 0);
        tick();
        check("x0_fwd", fwd_sel_e, 0);

        // Youngest wins: x9 at entries 0 and 1.
        drain();
        put(1, 9, 1, 0, 1, 2, 0);
        tick();
        put(1, 9, 1, 0, 3, 4, 0);
        tick();
        put(1, 11, 1, 0, 9, 0, 0);
        #1 check("yw_stall", stall_d, 0);
        tick();
        check("yw_fwd", fwd_sel_e, 4'b0001);

        // Enable low freezes state; combinational outputs still track it.
        drain();
        put(1, 16, 1, 1, 1, 0, 0);
        tick();
        put(1, 17, 1, 0, 16, 0, 0);
        #1 check("ena_stall", stall_d, 1);
        ena = 1'b0;
        tick();
        tick();
        check("ena_hold_count", stall_count, 1);
        check("ena_hold_stall", stall_d, 1);
        ena = 1'b1;
        tick();
        check("ena_resume_count", stall_count, 2);
        check("ena_resume_stall", stall_d, 0);
        tick();
        check("ena_fwd", fwd_sel_e, 4'b0010);

        // Reset asserted mid-stall: outputs clear without a clock edge.
        drain();
        put(1, 12, 1, 1, 1, 0, 0);
        tick();
        put(1, 13, 1, 0, 12, 12, 0);
        #1 check("mr_stall", stall_d, 1);
        #1 rst = 1'b1;
        redirect_e = 1'b1;
        #1 check("mr_stall_f", stall_f, 0);
        check("mr_stall_d", stall_d, 0);
        check("mr_flush_d", flush_d, 0);
        check("mr_flush_e", flush_e, 0);
        check("mr_fwd", fwd_sel_e, 0);
        check("mr_count", stall_count, 0);
        check("mr_sat_count", s_stall_count, 0);
        tick();
        rst = 1'b0;
        put(1, 13, 1, 0, 12, 12, 0);
        #1 check("post_rst_stall", stall_d, 0);
        check("post_rst_flush_e", flush_e, 0);

        // Five single-cycle load-use stalls saturate the 2-bit counter.
        drain();
        for (int n = 0; n < 5; n++) begin
            put(1, 14, 1, 1, 1, 0, 0);
            tick();
            put(1, 15, 1, 0, 14, 0, 0);
            tick();
            tick();
        end
        drain();
        check("sat_count", s_stall_count, 3);
        check("wide_count", stall_count, 5);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
